exc_sequencer: RTL and testbench

EXC_SEQUENCER -- requirements
Module: exc_sequencer

---
 rtl/exc_sequencer.sv | 136 +++++++++++++
 tb/tb_exc_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and ERET sequencer: drives CP0 EPC/Cause/Status writes and the PC redirect.
// Optional macro EXC_SEQ_IRQ_SYNC_EN adds a 2-flop synchronizer on each irq line.
module exc_sequencer #(
    parameter int          NUM_IRQ      = 4,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [31:0]        ins,
    input  logic [31:0]        pc,
    input  logic [31:0]        status,
    input  logic [31:0]        epc,
    output logic               cp0_wen,
    output logic [4:0]         cp0_addr,
    output logic [31:0]        cp0_wdata,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               flush,
    output logic               stall,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [2:0] {IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, JUMP, ERET_ST} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] irq_s, prev_low, irq_edge, clr_mask;
    logic [NUM_IRQ-1:0] cap_snap;
    logic [31:0]        cap_status, cause;
    logic               cap_irq;
    logic               is_sys, is_eret, take_irq, trig;
    logic               unused;

`ifdef EXC_SEQ_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1, sync2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end
    assign irq_s = sync2;
`else
    assign irq_s = irq;
`endif

    // prev_low resets to 0, so a line already high out of reset must fall first
    assign irq_edge = irq_s & prev_low;
    assign clr_mask = (state == JUMP && cap_irq) ? (pending & (~pending + NUM_IRQ'(1))) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_low <= '0;
            pending  <= '0;
        end else begin
            prev_low <= ~irq_s;
            pending  <= (pending & ~clr_mask) | irq_edge;
        end
    end

    assign is_sys   = (ins[31:26] == 6'd0) && (ins[5:0] == 6'b001100);
    assign is_eret  = (ins[31:26] == 6'b010000) && (ins[25:21] == 5'b10000);
    assign take_irq = status[0] && !status[1] && (|pending);
    assign trig     = is_sys || take_irq || is_eret;
    assign stall    = rst_n && ((state != IDLE) || trig);
    assign flush    = redirect;
    assign unused   = ^ins[20:6];

    always_comb begin
        cause                = '0;
        cause[6:2]           = cap_irq ? 5'd0 : 5'd8;
        cause[8 +: NUM_IRQ]  = cap_snap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cap_irq     <= 1'b0;
            cap_snap    <= '0;
            cap_status  <= '0;
            cp0_wen     <= 1'b0;
            cp0_addr    <= '0;
            cp0_wdata   <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            cp0_wen     <= 1'b0;
            cp0_addr    <= '0;
            cp0_wdata   <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            case (state)
                IDLE: begin
                    if (is_sys || take_irq) begin
                        state      <= SAVE_EPC;
                        cap_irq    <= !is_sys;
                        cap_snap   <= pending;
                        cap_status <= status;
                        cp0_wen    <= 1'b1;
                        cp0_addr   <= 5'd14;
                        cp0_wdata  <= pc;
                    end else if (is_eret) begin
                        state       <= ERET_ST;
                        cp0_wen     <= 1'b1;
                        cp0_addr    <= 5'd12;
                        cp0_wdata   <= status & ~32'h2;
                        redirect    <= 1'b1;
                        redirect_pc <= epc;
                    end
                end
                SAVE_EPC: begin
                    state     <= SAVE_CAUSE;
                    cp0_wen   <= 1'b1;
                    cp0_addr  <= 5'd13;
                    cp0_wdata <= cause;
                end
                SAVE_CAUSE: begin
                    state     <= SAVE_STATUS;
                    cp0_wen   <= 1'b1;
                    cp0_addr  <= 5'd12;
                    cp0_wdata <= cap_status | 32'h2;
                end
                SAVE_STATUS: begin
                    state       <= JUMP;
                    redirect    <= 1'b1;
                    redirect_pc <= HANDLER_ADDR;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// Randomized + directed bench for exc_sequencer; a queue-based model of each
// entry/ERET sequence predicts outputs cycle by cycle.
module tb_exc_sequencer;

    localparam logic [31:0] HANDLER = 32'h0000_0080;
    localparam logic [31:0] SYS = 32'h0000_000C;
    localparam logic [31:0] ERET = 32'h4200_0018;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  irq = '0;
    logic [31:0] ins = NOP, pc = '0, status = '0, epc = '0;
    logic        cp0_wen, redirect, flush, stall;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata, redirect_pc;
    logic [3:0]  pending;

    exc_sequencer #(.NUM_IRQ(4), .HANDLER_ADDR(HANDLER)) dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .ins(ins), .pc(pc), .status(status), .epc(epc),
        .cp0_wen(cp0_wen), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .stall(stall), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        rd;
        logic [31:0] rpc;
        logic        clr;
    } exp_t;

    exp_t       q[$];
    logic [3:0] mpend = '0;
    logic [3:0] last_seen = 4'hF;
    int         n_cmp = 0, n_err = 0;

    function automatic exp_t mk(logic w, logic [4:0] a, logic [31:0] d, logic r, logic [31:0] p, logic c);
        exp_t e;
        e.wen = w; e.addr = a; e.wdata = d; e.rd = r; e.rpc = p; e.clr = c;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(exp_t e);
        chk("cp0_wen", 32'(cp0_wen), 32'(e.wen));
        chk("cp0_addr", 32'(cp0_addr), 32'(e.addr));
        chk("cp0_wdata", cp0_wdata, e.wdata);
        chk("redirect", 32'(redirect), 32'(e.rd));
        chk("flush", 32'(flush), 32'(e.rd));
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("pending", 32'(pending), 32'(mpend));
    endtask

    // Called at negedge: assert reset, check outputs drop at once, release a cycle later
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        mpend = '0;
        last_seen = 4'hF;
        chk("rst_stall", 32'(stall), 32'd0);
        chk_outs(mk(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: inputs already set at negedge; ends at the next negedge
    task automatic cycle();
        logic sys, er, it, trig;
        logic [3:0] edges;
        exp_t e;
        sys  = (ins[31:26] == 6'd0) && (ins[5:0] == 6'b001100);
        er   = (ins[31:26] == 6'b010000) && (ins[25:21] == 5'b10000);
        it   = status[0] && !status[1] && (mpend != 4'd0);
        trig = sys || it || er;
        #1 chk("stall", 32'(stall), 32'((q.size() != 0) || trig));
        @(posedge clk);
        edges = irq & ~last_seen;
        if (q.size() == 0 && trig) begin
            if (sys || it) begin
                q.push_back(mk(1'b1, 5'd14, pc, 1'b0, 32'd0, 1'b0));
                q.push_back(mk(1'b1, 5'd13, ((sys ? 32'd8 : 32'd0) << 2) | (32'(mpend) << 8), 1'b0, 32'd0, 1'b0));
                q.push_back(mk(1'b1, 5'd12, status | 32'h2, 1'b0, 32'd0, 1'b0));
                q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, HANDLER, 1'b0));
                q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, !sys));
            end else begin
                q.push_back(mk(1'b1, 5'd12, status & ~32'h2, 1'b1, epc, 1'b0));
                q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0));
            end
        end
        e = mk(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        if (q.size() != 0) e = q.pop_front();
        if (e.clr) begin
            for (int i = 0; i < 4; i++)
                if (mpend[i]) begin
                    mpend[i] = 1'b0;
                    break;
                end
        end
        mpend = mpend | edges;
        last_seen = irq;
        #1 chk_outs(e);
        @(negedge clk);
    endtask

    initial begin
        // Reset with irq[0] already high: must not register as an edge afterwards
        irq = 4'b0001;
        @(negedge clk);
        do_reset();
        repeat (3) cycle();
        chk("r033_no_edge", 32'(pending), 32'd0);
        irq = 4'b0000; cycle();
        irq = 4'b0001; cycle();
        chk("r033_new_edge", 32'(pending), 32'd1);
        irq = 4'b0000;
        do_reset();

        // SYSCALL entry
        pc = 32'h40; status = 32'h1; ins = SYS;
        cycle(); chk("r036_epc", cp0_wdata, 32'h40);
        ins = NOP;
        cycle(); chk("r036_cause", cp0_wdata, 32'h20);
        cycle(); chk("r036_status", cp0_wdata, 32'h3);
        cycle(); chk("r036_rpc", redirect_pc, 32'h80);
        cycle();

        // Interrupt entry on irq[2]
        irq = 4'b0100; cycle(); chk("r037_pend", 32'(pending), 32'h4);
        irq = 4'b0000;
        cycle(); cycle(); chk("r037_cause", cp0_wdata, 32'h400);
        repeat (3) cycle(); chk("r037_clear", 32'(pending), 32'h0);

        // Interrupt held off by EXL
        status = 32'h3; irq = 4'b0010; cycle();
        irq = 4'b0000;
        repeat (4) cycle();
        chk("r038_nowr", 32'(cp0_wen), 32'd0);
        chk("r038_held", 32'(pending), 32'h2);
        status = 32'h1; cycle(); chk("r038_take", 32'(cp0_addr), 32'd14);
        repeat (5) cycle();

        // ERET
        status = 32'h3; epc = 32'h44; ins = ERET;
        cycle();
        chk("r039_wdata", cp0_wdata, 32'h1);
        chk("r039_rpc", redirect_pc, 32'h44);
        ins = NOP; cycle();

        // SYSCALL beats pending irq[0], then interrupt runs; reset mid-sequence
        status = 32'h3; irq = 4'b0001; cycle();
        irq = 4'b0000; status = 32'h1; ins = SYS; pc = 32'h100;
        cycle(); ins = NOP;
        cycle(); chk("r040_sys_cause", cp0_wdata, 32'h120);
        repeat (3) cycle();
        cycle(); chk("r040_irq_epc", 32'(cp0_addr), 32'd14);
        cycle(); chk("r040_in_cause", 32'(cp0_addr), 32'd13);
        do_reset();
        cycle(); chk("r040_no_status", 32'(cp0_wen), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] r;
            r = $urandom;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
            case ($urandom_range(0, 5))
                0:       ins = {6'd0, r[25:6], 6'b001100};
                1:       ins = {11'b010000_10000, r[20:0]};
                default: ins = r;
            endcase
            case ($urandom_range(0, 3))
                0:       status = 32'h3;
                1:       status = 32'h0;
                default: status = {r[31:2], 2'b01};
            endcase
            pc  = $urandom;
            epc = $urandom;
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
